// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage: decode payload, hazard control,
// fetch FSM states and the canonical NOP encoding.
package fetch_stage_pkg;

    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] programCounter;
        logic [31:0] programCounterPlus4;
        logic        valid;
    } fetchDecodePayload_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } fetchDecodeControl_t;

    typedef enum logic [1:0] {
        FETCH_REQUEST,
        FETCH_WAIT,
        FETCH_HOLD
    } fetchState_t;

    function automatic fetchDecodePayload_t make_payload(input logic [31:0] instr,
                                                         input logic [31:0] pc);
        fetchDecodePayload_t p;
        p.instruction         = instr;
        p.programCounter      = pc;
        p.programCounterPlus4 = pc + 32'd4;
        p.valid               = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, single-outstanding imem requests, one-entry
// stall buffer. Define FETCH_PERF_COUNTERS_EN to add fetched/discarded counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  fetchDecodeControl_t fetchDecodeControl,
    input  logic                redirectValid,
    input  logic [31:0]         redirectTarget,
    output logic                imemRequestValid,
    input  logic                imemRequestReady,
    output logic [31:0]         imemRequestAddress,
    input  logic                imemResponseValid,
    input  logic [31:0]         imemResponseData,
    output fetchDecodePayload_t fetchDecodePayload
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]         fetchedCount,
    output logic [31:0]         discardedCount
`endif
);

    fetchState_t         state_q;
    logic [31:0]         pc_q;
    logic [31:0]         req_pc_q;
    logic [31:0]         buf_instr_q;
    logic                discard_q;
    fetchDecodePayload_t payload_q;

    logic                stall;
    logic                flush;
    logic [31:0]         write_instr;
    fetchDecodePayload_t payload_d;

    assign stall       = fetchDecodeControl.stall;
    assign flush       = fetchDecodeControl.flush;
    assign write_instr = (state_q == FETCH_HOLD) ? buf_instr_q : imemResponseData;
    assign payload_d   = make_payload(write_instr, req_pc_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH_REQUEST;
            pc_q      <= RESET_VECTOR;
            req_pc_q  <= RESET_VECTOR;
            discard_q <= 1'b0;
            payload_q <= '0;
        end else begin
            // Decode consumes the payload on any unstalled edge.
            if (!stall) begin
                payload_q.valid <= 1'b0;
            end

            if (redirectValid) begin
                pc_q <= redirectTarget;
                case (state_q)
                    FETCH_REQUEST: begin
                        if (imemRequestReady) begin
                            state_q   <= FETCH_WAIT;
                            discard_q <= 1'b1;
                        end
                    end
                    FETCH_WAIT: begin
                        if (imemResponseValid) begin
                            state_q   <= FETCH_REQUEST;
                            discard_q <= 1'b0;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end
                    default: state_q <= FETCH_REQUEST;
                endcase
            end else begin
                case (state_q)
                    FETCH_REQUEST: begin
                        if (imemRequestReady) begin
                            req_pc_q <= pc_q;
                            state_q  <= FETCH_WAIT;
                        end
                    end
                    FETCH_WAIT: begin
                        if (imemResponseValid) begin
                            if (discard_q) begin
                                discard_q <= 1'b0;
                                state_q   <= FETCH_REQUEST;
                            end else if (!stall) begin
                                payload_q <= payload_d;
                                pc_q      <= payload_d.programCounterPlus4;
                                state_q   <= FETCH_REQUEST;
                            end else begin
                                buf_instr_q <= imemResponseData;
                                state_q     <= FETCH_HOLD;
                            end
                        end
                    end
                    FETCH_HOLD: begin
                        if (!stall) begin
                            payload_q <= payload_d;
                            pc_q      <= payload_d.programCounterPlus4;
                            state_q   <= FETCH_REQUEST;
                        end
                    end
                    default: state_q <= FETCH_REQUEST;
                endcase
            end

            if (flush) begin
                payload_q.valid <= 1'b0;
            end
        end
    end

    // Request valid is a pure function of state, so no path from the response side.
    assign imemRequestValid   = (state_q == FETCH_REQUEST) && !reset;
    assign imemRequestAddress = pc_q;
    assign fetchDecodePayload = payload_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic        resp_in_wait;
    logic        write_en;
    logic        drop_en;
    logic [31:0] fetched_q;
    logic [31:0] discarded_q;

    assign resp_in_wait = (state_q == FETCH_WAIT) && imemResponseValid;
    assign write_en     = !redirectValid && !stall &&
                          ((resp_in_wait && !discard_q) || (state_q == FETCH_HOLD));
    assign drop_en      = (redirectValid && (resp_in_wait || (state_q == FETCH_HOLD))) ||
                          (!redirectValid && resp_in_wait && discard_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            if (write_en) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (drop_en) begin
                discarded_q <= discarded_q + 32'd1;
            end
        end
    end

    assign fetchedCount   = fetched_q;
    assign discardedCount = discarded_q;
`endif

endmodule
